// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register: one-cycle latency, stall holds, flush inserts a bubble, x0 writes suppressed.
// Optional retired-instruction counter built only when MEM_WB_RETIRE_CNT_EN is defined (else tied to 0).
module mem_wb_stage_reg #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int RETIRE_W   = 32
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic                           stall,
   input  logic                           flush,
   input  logic                           writeback,
   input  logic                           is_call,
   input  logic [XLEN-1:0]                pc,
   input  logic [XLEN-1:0]                load_data,
   input  logic [REG_ADDR_W-1:0]          rd_field,
   output logic [2+2*XLEN+REG_ADDR_W-1:0] M_WB_register,
   output logic                           wb_valid,
   output logic                           wb_en,
   output logic [REG_ADDR_W-1:0]          wb_rd,
   output logic [XLEN-1:0]                wb_data,
   output logic [RETIRE_W-1:0]            retire_count
);

   typedef struct packed {
      logic                  writeback;
      logic                  is_call;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       load_data;
      logic [REG_ADDR_W-1:0] rd_field;
   } mem_wb_t;

   mem_wb_t stage_q;
   logic    valid_q;
   logic    load_en;

   assign load_en = !flush && !stall;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage_q <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         stage_q <= '0;
         valid_q <= 1'b0;
      end else if (!stall) begin
         valid_q           <= in_valid;
         // Bubbles and x0 targets never raise the write enable downstream.
         stage_q.writeback <= writeback && in_valid && (rd_field != '0);
         stage_q.is_call   <= is_call && in_valid;
         stage_q.pc        <= pc;
         stage_q.load_data <= load_data;
         stage_q.rd_field  <= rd_field;
      end
   end

   assign M_WB_register = stage_q;
   assign wb_valid      = valid_q;
   assign wb_en         = valid_q && stage_q.writeback;
   assign wb_rd         = stage_q.rd_field;
   // Call link address wraps modulo 2^XLEN.
   assign wb_data       = stage_q.is_call ? (stage_q.pc + XLEN'(4)) : stage_q.load_data;

`ifdef MEM_WB_RETIRE_CNT_EN
   logic [RETIRE_W-1:0] retire_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         retire_q <= '0;
      end else if (load_en && in_valid) begin
         retire_q <= retire_q + RETIRE_W'(1);
      end
   end

   assign retire_count = retire_q;
`else
   assign retire_count = '0;
`endif

endmodule
